// File: rtl/plru_way_select_pkg.sv
// Shared constants for the 8-way tree pseudo-LRU way selector.
// Tree node numbering: root, the two half-nodes, then the four pair-leaves.
package plru_way_select_pkg;

  localparam int WAYS      = 8;
  localparam int WAY_BITS  = $clog2(WAYS);
  localparam int TREE_BITS = WAYS - 1;

  localparam int ND_ROOT  = 0;
  localparam int ND_LEFT  = 1;
  localparam int ND_RIGHT = 2;
  localparam int ND_LEAF0 = 3;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

endpackage

// File: rtl/plru_way_select_tree_update.sv
// Combinational PLRU tree step: victim from the current bits, and the bits
// after touching a way (every node on the way's path points away from it).
module plru_tree_update
  import plru_way_select_pkg::*;
(
  input  logic [TREE_BITS-1:0] t_in,
  input  logic [WAY_BITS-1:0]  way,
  output logic [TREE_BITS-1:0] t_out,
  output logic [WAY_BITS-1:0]  victim
);

  logic [2:0] vic_leaf;
  logic [2:0] upd_leaf;
  logic       vic_half;

  always_comb begin
    vic_half = t_in[ND_ROOT] ? t_in[ND_RIGHT] : t_in[ND_LEFT];
    vic_leaf = 3'(ND_LEAF0) + {1'b0, t_in[ND_ROOT], vic_half};
    victim   = {t_in[ND_ROOT], vic_half, t_in[vic_leaf]};
  end

  always_comb begin
    t_out          = t_in;
    upd_leaf       = 3'(ND_LEAF0) + {1'b0, way[2:1]};
    t_out[ND_ROOT] = ~way[2];
    if (way[2]) t_out[ND_RIGHT] = ~way[1];
    else        t_out[ND_LEFT]  = ~way[1];
    t_out[upd_leaf] = ~way[0];
  end

endmodule

// File: rtl/plru_way_select.sv
// Per-set tree PLRU way select for the 8-way L2: hit way on hit, victim on miss.
// Optional PLRU_STATS_EN adds saturating hit/miss counters.
module plru_way_select
  import plru_way_select_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int SETS       = 2 ** INDEX_BITS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [INDEX_BITS-1:0] req_index,
  input  logic                  req_hit,
  input  logic [WAY_BITS-1:0]   req_hit_way,
  output logic                  sel_valid,
  output logic [WAY_BITS-1:0]   sel_way,
  output logic                  sel_miss
`ifdef PLRU_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  state_e                state_q, state_d;
  logic [INDEX_BITS-1:0] init_idx_q, init_idx_d;
  logic                  sel_valid_q, sel_valid_d;
  logic [WAY_BITS-1:0]   sel_way_q, sel_way_d;
  logic                  sel_miss_q, sel_miss_d;

  logic [TREE_BITS-1:0]  tree_q [SETS];
  logic                  wr_en;
  logic [INDEX_BITS-1:0] wr_idx;
  logic [TREE_BITS-1:0]  wr_data;

  logic [TREE_BITS-1:0]  t_cur, t_new;
  logic [WAY_BITS-1:0]   victim, upd_way;
  logic                  accept;

  assign t_cur   = tree_q[req_index];
  // Mux rather than gating keeps an undriven hit_way out of the miss path.
  assign upd_way = req_hit ? req_hit_way : victim;

  plru_tree_update u_tree (
    .t_in   (t_cur),
    .way    (upd_way),
    .t_out  (t_new),
    .victim (victim)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    init_idx_d  = init_idx_q;
    sel_valid_d = 1'b0;
    sel_way_d   = sel_way_q;
    sel_miss_d  = sel_miss_q;
    wr_en       = 1'b0;
    wr_idx      = init_idx_q;
    wr_data     = '0;
    case (state_q)
      ST_INIT: begin
        wr_en = 1'b1;
        if (init_idx_q == INDEX_BITS'(SETS - 1)) begin
          state_d = ST_IDLE;
        end else begin
          init_idx_d = init_idx_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (accept) begin
          wr_en       = 1'b1;
          wr_idx      = req_index;
          wr_data     = t_new;
          sel_valid_d = 1'b1;
          sel_way_d   = upd_way;
          sel_miss_d  = ~req_hit;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_INIT;
      init_idx_q  <= '0;
      sel_valid_q <= 1'b0;
      sel_way_q   <= '0;
      sel_miss_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_idx_q  <= init_idx_d;
      sel_valid_q <= sel_valid_d;
      sel_way_q   <= sel_way_d;
      sel_miss_q  <= sel_miss_d;
    end
  end

  // Writing at the accept edge lets a back-to-back request to the same set
  // read the updated bits directly from the array.
  always_ff @(posedge clock) begin
    if (!reset && wr_en) begin
      tree_q[wr_idx] <= wr_data;
    end
  end

  assign sel_valid = sel_valid_q;
  assign sel_way   = sel_way_q;
  assign sel_miss  = sel_miss_q;

`ifdef PLRU_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (accept && req_hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
      hit_cnt_d = hit_cnt_q + 32'd1;
    end
    if (accept && !req_hit && (miss_cnt_q != 32'hFFFF_FFFF)) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_plru_way_select.sv
// Randomized bench for plru_way_select against a heap-indexed tree PLRU model.
// Build with PLRU_STATS_EN to also check the hit/miss counters.
module tb_plru_way_select;

  logic       clock = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [5:0] req_index;
  logic       req_hit;
  logic [2:0] req_hit_way;
  logic       sel_valid;
  logic [2:0] sel_way;
  logic       sel_miss;
`ifdef PLRU_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  always #5 clock = ~clock;

  plru_way_select dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_index   (req_index),
    .req_hit     (req_hit),
    .req_hit_way (req_hit_way),
    .sel_valid   (sel_valid),
    .sel_way     (sel_way),
    .sel_miss    (sel_miss)
`ifdef PLRU_STATS_EN
    ,
    .hit_count   (hit_count),
    .miss_count  (miss_count)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  int mtree [64][7];
  int m_hits = 0;
  int m_misses = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: node n has children 2n+1 (left) and 2n+2 (right); leaves 7..14 = ways 0..7.
  function automatic int model_victim(input int s);
    int n = 0;
    repeat (3) n = 2 * n + 1 + mtree[s][n];
    return n - 7;
  endfunction

  task automatic model_touch(input int s, input int w);
    int n = w + 7;
    while (n > 0) begin
      int p = (n - 1) / 2;
      mtree[s][p] = (n == 2 * p + 1) ? 1 : 0;
      n = p;
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 64; s++)
      for (int k = 0; k < 7; k++) mtree[s][k] = 0;
    m_hits = 0;
    m_misses = 0;
  endtask

  // One cycle in IDLE: present inputs, clock, check the registered result.
  task automatic step(input logic v, input int idx, input logic h, input int hw,
                      output int got_way);
    int exp_way = 0;
    chk("ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid   = v;
    req_index   = 6'(idx);
    req_hit     = h;
    req_hit_way = h ? 3'(hw) : 3'bx;
    if (v) begin
      exp_way = h ? hw : model_victim(idx);
      model_touch(idx, exp_way);
      if (h) m_hits++; else m_misses++;
    end
    @(posedge clock); #1;
    req_valid = 1'b0;
    got_way = int'(sel_way);
    chk("sel_valid", {31'd0, sel_valid}, {31'd0, v});
    if (v) begin
      chk("sel_way", {29'd0, sel_way}, 32'(exp_way));
      chk("sel_miss", {31'd0, sel_miss}, {31'd0, ~h});
    end
  endtask

  // Assert reset for one edge (optionally with a request present), then time INIT.
  task automatic do_reset(input logic with_req);
    int low_cycles = 0;
    bit saw_valid = 0;
    reset = 1'b1;
    req_valid = with_req;
    req_index = 6'd9;
    req_hit = 1'b0;
    req_hit_way = 3'd0;
    model_reset();
    @(posedge clock); #1;
    req_valid = 1'b0;
    chk("rst_sel_valid", {31'd0, sel_valid}, 32'd0);
    chk("rst_sel_way", {29'd0, sel_way}, 32'd0);
    chk("rst_sel_miss", {31'd0, sel_miss}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
`ifdef PLRU_STATS_EN
    chk("rst_hit_count", hit_count, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
`endif
    reset = 1'b0;
    while (low_cycles < 200) begin
      @(negedge clock);
      if (sel_valid) saw_valid = 1;
      if (req_ready) break;
      low_cycles++;
    end
    chk("init_low_cycles", 32'(low_cycles), 32'd64);
    chk("init_no_sel_valid", {31'd0, saw_valid}, 32'd0);
  endtask

  initial begin
    int w;
    int exp2 [9] = '{0, 4, 2, 6, 1, 5, 3, 7, 0};
    reset = 1'b0;
    req_valid = 1'b0;
    req_index = '0;
    req_hit = 1'b0;
    req_hit_way = '0;
    @(negedge clock);

    do_reset(1'b0);

    for (int i = 0; i < 9; i++) begin
      step(1'b1, 5, 1'b0, 0, w);
      chk("seq_miss_way", 32'(w), 32'(exp2[i]));
    end

    do_reset(1'b0);
    step(1'b1, 5, 1'b1, 0, w);
    chk("hit0_way", 32'(w), 32'd0);
    step(1'b1, 5, 1'b0, 0, w);
    chk("miss_after_hit0", 32'(w), 32'd4);

    step(1'b1, 3, 1'b0, 0, w);
    chk("set3_first", 32'(w), 32'd0);
    step(1'b1, 4, 1'b0, 0, w);
    chk("set4_first", 32'(w), 32'd0);

    do_reset(1'b1);

`ifdef PLRU_STATS_EN
    step(1'b1, 1, 1'b1, 2, w);
    step(1'b1, 1, 1'b0, 0, w);
    step(1'b1, 2, 1'b1, 7, w);
    step(1'b1, 1, 1'b1, 5, w);
    step(1'b1, 2, 1'b0, 0, w);
    step(1'b0, 0, 1'b0, 0, w);
    chk("stats_hits", hit_count, 32'd3);
    chk("stats_misses", miss_count, 32'd2);
    do_reset(1'b0);
`endif

    for (int i = 0; i < 600; i++) begin
      step(($urandom % 4) != 0, int'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(0, 7)), w);
    end
    step(1'b0, 0, 1'b0, 0, w);
`ifdef PLRU_STATS_EN
    chk("rand_hits", hit_count, 32'(m_hits));
    chk("rand_misses", miss_count, 32'(m_misses));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
